// File: rtl/axppa_pkg.sv
// Shared types and default sizing for the approximate prefix adder characterisation blocks.
package axppa_pkg;

  localparam int AXPPA_WIDTH = 16;
  localparam int AXPPA_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } axppa_state_t;

  typedef struct packed {
    logic [AXPPA_WIDTH:1] op_a;
    logic [AXPPA_WIDTH:1] op_b;
    logic                 carry_in;
    logic [AXPPA_WIDTH:1] approx_sum;
    logic                 approx_cout;
  } axppa_sample_t;

endpackage

// File: rtl/axppa_ed_calc.sv
// Combinational exact sum and absolute error distance against an approximate adder result.
module axppa_ed_calc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:1] op_a,
  input  logic [WIDTH:1] op_b,
  input  logic           carry_in,
  input  logic [WIDTH:1] approx_sum,
  input  logic           approx_cout,
  output logic [WIDTH:0] exact,
  output logic [WIDTH:0] approx,
  output logic [WIDTH:0] ed
);

  always_comb begin
    exact  = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry_in};
    approx = {approx_cout, approx_sum};
    ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

endmodule

// File: rtl/axppa_error_monitor.sv
// Windowed error-rate / error-distance collector for approximate adders (3-stage pipeline).
module axppa_error_monitor
  import axppa_pkg::*;
#(
  parameter int          WIDTH   = AXPPA_WIDTH,
  parameter int          CNT_W   = AXPPA_CNT_W,
  parameter int unsigned SAMPLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   op_a,
  input  logic [WIDTH:1]   op_b,
  input  logic             carry_in,
  input  logic [WIDTH:1]   approx_sum,
  input  logic             approx_cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] ed_sum,
  output logic [WIDTH:0]   ed_max
);

  typedef struct packed {
    logic [WIDTH:1] op_a;
    logic [WIDTH:1] op_b;
    logic           carry_in;
    logic [WIDTH:1] approx_sum;
    logic           approx_cout;
  } sample_t;

  // Sum is formed wide enough to hold either operand plus a carry before saturating.
  localparam int SW = ((CNT_W > WIDTH + 1) ? CNT_W : WIDTH + 1) + 1;

  axppa_state_t   state, state_nxt;
  logic           drain_cnt;
  logic           accept, last_accept, zero_res;
  logic           s1_vld, s2_vld, s2_err;
  sample_t        s1;
  logic [WIDTH:0] s2_ed;
  logic [WIDTH:0] calc_exact, calc_approx, calc_ed;
  logic [SW-1:0]  sum_ext;

  assign in_ready    = (state == RUN) && (sample_count < CNT_W'(SAMPLES));
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_count == CNT_W'(SAMPLES - 1));
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  always_comb begin
    state_nxt = state;
    zero_res  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      zero_res  = 1'b1;
    end else begin
      case (state)
        IDLE:  if (start) begin state_nxt = RUN; zero_res = 1'b1; end
        RUN:   if (last_accept) state_nxt = DRAIN;
        DRAIN: if (drain_cnt) state_nxt = DONE;
        DONE:  if (start) begin state_nxt = RUN; zero_res = 1'b1; end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !clear ? ~drain_cnt : 1'b0;
    end
  end

  axppa_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
    .op_a        (s1.op_a),
    .op_b        (s1.op_b),
    .carry_in    (s1.carry_in),
    .approx_sum  (s1.approx_sum),
    .approx_cout (s1.approx_cout),
    .exact       (calc_exact),
    .approx      (calc_approx),
    .ed          (calc_ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
      s2_vld <= 1'b0;
      s2_ed  <= '0;
      s2_err <= 1'b0;
    end else begin
      s1_vld <= accept && !clear;
      s2_vld <= s1_vld && !clear;
      if (accept) s1 <= '{op_a, op_b, carry_in, approx_sum, approx_cout};
      s2_ed  <= calc_ed;
      s2_err <= (calc_exact != calc_approx);
    end
  end

  assign sum_ext = SW'(ed_sum) + SW'(s2_ed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
    end else if (zero_res) begin
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
    end else begin
      if (accept) sample_count <= sample_count + CNT_W'(1);
      if (s2_vld) begin
        err_count <= err_count + CNT_W'(s2_err);
        ed_sum    <= (sum_ext > SW'({CNT_W{1'b1}})) ? '1 : sum_ext[CNT_W-1:0];
        if (s2_ed > ed_max) ed_max <= s2_ed;
      end
    end
  end

endmodule

// File: tb/tb_axppa_error_monitor.sv
// Directed bench for axppa_error_monitor: four instances with different window sizes, scoreboard of per-sample ED.
module tb_axppa_error_monitor;
  import axppa_pkg::*;

  logic        clk, rst_n, clear, in_valid, carry_in, approx_cout;
  logic [16:1] op_a, op_b, approx_sum;
  logic [3:0]  start_v;
  int unsigned sel;

  logic        rdy1, rdy3, rdy4, rdy8, bsy1, bsy3, bsy4, bsy8, dn1, dn3, dn4, dn8;
  logic [31:0] sc1, sc3, sc4, er1, er3, er4, sm1, sm3, sm4;
  logic [7:0]  sc8, er8, sm8;
  logic [16:0] mx1, mx3, mx4, mx8;

  logic        cur_ready, cur_busy, cur_done;
  logic [31:0] cur_sc, cur_err, cur_sum;
  logic [16:0] cur_max;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  axppa_error_monitor #(.WIDTH(16), .CNT_W(32), .SAMPLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy1), .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
    .approx_cout(approx_cout), .busy(bsy1), .done(dn1), .sample_count(sc1), .err_count(er1),
    .ed_sum(sm1), .ed_max(mx1));
  axppa_error_monitor #(.WIDTH(16), .CNT_W(32), .SAMPLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy3), .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
    .approx_cout(approx_cout), .busy(bsy3), .done(dn3), .sample_count(sc3), .err_count(er3),
    .ed_sum(sm3), .ed_max(mx3));
  axppa_error_monitor #(.WIDTH(16), .CNT_W(32), .SAMPLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy4), .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
    .approx_cout(approx_cout), .busy(bsy4), .done(dn4), .sample_count(sc4), .err_count(er4),
    .ed_sum(sm4), .ed_max(mx4));
  axppa_error_monitor #(.WIDTH(16), .CNT_W(8), .SAMPLES(80)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy8), .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .approx_sum(approx_sum),
    .approx_cout(approx_cout), .busy(bsy8), .done(dn8), .sample_count(sc8), .err_count(er8),
    .ed_sum(sm8), .ed_max(mx8));

  always_comb begin
    cur_ready = rdy1; cur_busy = bsy1; cur_done = dn1;
    cur_sc = sc1; cur_err = er1; cur_sum = sm1; cur_max = mx1;
    case (sel)
      1: begin cur_ready = rdy3; cur_busy = bsy3; cur_done = dn3;
               cur_sc = sc3; cur_err = er3; cur_sum = sm3; cur_max = mx3; end
      2: begin cur_ready = rdy4; cur_busy = bsy4; cur_done = dn4;
               cur_sc = sc4; cur_err = er4; cur_sum = sm4; cur_max = mx4; end
      3: begin cur_ready = rdy8; cur_busy = bsy8; cur_done = dn8;
               cur_sc = 32'(sc8); cur_err = 32'(er8); cur_sum = 32'(sm8); cur_max = mx8; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_ed(input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic [15:0] s, input logic co);
    logic [16:0] ex, ap;
    ex = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    ap = {co, s};
    return (ex >= ap) ? ex - ap : ap - ex;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int unsigned s);
    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v = '0;
  endtask

  // Drives one sample; it is accepted at the coming rising edge if in_ready is high now.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] s, input logic co);
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; carry_in = ci; approx_sum = s; approx_cout = co;
    if (cur_ready) exp_q.push_back(model_ed(a, b, ci, s, co));
  endtask

  task automatic idle_cycle();
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic finish_window(input string tag, input longint sat, input int n_exp);
    longint acc;
    int     errs;
    logic [16:0] mx, e;
    @(negedge clk);
    check({tag, "_ready_low"}, 64'(cur_ready), 64'd0);
    check({tag, "_done_n1"}, 64'(cur_done), 64'd0);
    check({tag, "_busy_drain"}, 64'(cur_busy), 64'd1);
    @(negedge clk);
    check({tag, "_done_n2"}, 64'(cur_done), 64'd0);
    @(negedge clk);
    check({tag, "_done_n3"}, 64'(cur_done), 64'd1);
    check({tag, "_busy_done"}, 64'(cur_busy), 64'd0);
    in_valid = 1'b0;
    acc = 0; errs = 0; mx = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e != 0) errs++;
      acc += longint'(e);
      if (acc > sat) acc = sat;
      if (e > mx) mx = e;
    end
    check({tag, "_sample_count"}, 64'(cur_sc), 64'(n_exp));
    check({tag, "_err_count"}, 64'(cur_err), 64'(errs));
    check({tag, "_ed_sum"}, 64'(cur_sum), 64'(acc));
    check({tag, "_ed_max"}, 64'(cur_max), 64'(mx));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; start_v = '0; sel = 3;
    op_a = '0; op_b = '0; carry_in = 1'b0; approx_sum = '0; approx_cout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(cur_busy), 64'd0);
    check("rst_done", 64'(cur_done), 64'd0);
    check("rst_ready", 64'(cur_ready), 64'd0);
    check("rst_sc", 64'(cur_sc), 64'd0);
    rst_n = 1'b1;

    // Reset mid-window with samples in flight, then a fresh saturating window.
    pulse_start(3);
    check("run_busy", 64'(cur_busy), 64'd1);
    check("run_ready", 64'(cur_ready), 64'd1);
    repeat (5) send(16'h0001, 16'h0001, 1'b0, 16'h0010, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("mid_rst_state", 64'(u8.state), 64'(IDLE));
    check("mid_rst_ready", 64'(cur_ready), 64'd0);
    check("mid_rst_busy", 64'(cur_busy), 64'd0);
    check("mid_rst_sc", 64'(cur_sc), 64'd0);
    check("mid_rst_err", 64'(cur_err), 64'd0);
    check("mid_rst_sum", 64'(cur_sum), 64'd0);
    check("mid_rst_max", 64'(cur_max), 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    pulse_start(3);
    repeat (80) send(16'h00FF, 16'h0001, 1'b0, 16'h00FC, 1'b0);
    finish_window("sat", 64'd255, 80);

    // Single-sample window, then clear together with start in DONE.
    sel = 0;
    pulse_start(0);
    send(16'h00FF, 16'h0001, 1'b0, 16'h00FC, 1'b0);
    finish_window("one", 64'hFFFF_FFFF, 1);
    check("one_ed_value", 64'(cur_sum), 64'd4);
    @(negedge clk); clear = 1'b1; start_v[0] = 1'b1;
    @(negedge clk); clear = 1'b0; start_v = '0;
    check("clr_state", 64'(u1.state), 64'(IDLE));
    check("clr_done", 64'(cur_done), 64'd0);
    check("clr_busy", 64'(cur_busy), 64'd0);
    check("clr_sc", 64'(cur_sc), 64'd0);
    check("clr_err", 64'(cur_err), 64'd0);
    check("clr_sum", 64'(cur_sum), 64'd0);
    check("clr_max", 64'(cur_max), 64'd0);
    @(negedge clk);
    check("clr_still_idle", 64'(cur_busy), 64'd0);

    // Back-to-back exact samples; in_valid stays high past the window.
    sel = 2;
    pulse_start(2);
    repeat (4) send(16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0);
    finish_window("b2b", 64'hFFFF_FFFF, 4);

    // Toggling in_valid with mixed error directions.
    sel = 1;
    pulse_start(1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0);
    idle_cycle();
    check("tog_sc_mid", 64'(cur_sc), 64'd1);
    send(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0);
    idle_cycle();
    check("tog_sc_mid2", 64'(cur_sc), 64'd2);
    send(16'h0001, 16'h0001, 1'b0, 16'h0010, 1'b0);
    finish_window("tog", 64'hFFFF_FFFF, 3);
    check("tog_max_const", 64'(cur_max), 64'h10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
